// File: rtl/rfphoenix_mc_wb_queue.sv
// rfphoenix_mc_wb_queue: merges single-cycle and multi-cycle FP results onto one register-file write port
module rfphoenix_mc_wb_queue #(
    parameter int WID   = 32,
    parameter int RIDW  = 4,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mc_issue,
    input  logic            mc_valid,
    input  logic [RIDW-1:0] mc_rid,
    input  logic [WID-1:0]  mc_res,
    input  logic            sc_valid,
    input  logic [RIDW-1:0] sc_rid,
    input  logic [WID-1:0]  sc_res,
    output logic            wr_en,
    output logic [RIDW-1:0] wr_rid,
    output logic [WID-1:0]  wr_res,
    output logic            mc_issue_ok,
    output logic            ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] FULL = DEPTH;
    localparam logic [AW+1:0] LIMIT = DEPTH;

    logic [RIDW+WID-1:0] mem_q [DEPTH];
    logic [AW-1:0]       rd_q, wr_q;
    logic [AW:0]         cnt_q, cnt_d, infl_q, infl_d;
    logic                wr_en_q, wr_en_d, ovf_q, empty, full, pop, byp, push, drop;
    logic [RIDW-1:0]     wr_rid_q;
    logic [WID-1:0]      wr_res_q;
    logic [RIDW+WID-1:0] sel;

    // Arbitration: SC first, then the FIFO head, then an MC bypass when nothing is queued
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == FULL;
        pop     = !sc_valid && !empty;
        byp     = !sc_valid && empty && mc_valid;
        push    = mc_valid && !byp && (!full || pop);
        drop    = mc_valid && !byp && full && !pop;
        wr_en_d = sc_valid || pop || byp;
        cnt_d   = cnt_q + (push ? ONE : '0) - (pop ? ONE : '0);
        infl_d  = (mc_issue && !mc_valid) ? infl_q + ONE :
                  (mc_valid && !mc_issue && infl_q != '0) ? infl_q - ONE : infl_q;
        sel     = sc_valid ? {sc_rid, sc_res} : pop ? mem_q[rd_q] : {mc_rid, mc_res};
    end

    // Queue pointers, credit counter, sticky overflow and the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            infl_q   <= '0;
            ovf_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            wr_rid_q <= '0;
            wr_res_q <= '0;
        end else begin
            rd_q    <= rd_q + (pop ? AW'(1) : AW'(0));
            wr_q    <= wr_q + (push ? AW'(1) : AW'(0));
            cnt_q   <= cnt_d;
            infl_q  <= infl_d;
            ovf_q   <= ovf_q || drop;
            wr_en_q <= wr_en_d;
            if (wr_en_d) {wr_rid_q, wr_res_q} <= sel;
        end
    end

    // FIFO storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {mc_rid, mc_res};
    end

    assign mc_issue_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) < LIMIT;
    assign wr_en       = wr_en_q;
    assign wr_rid      = wr_rid_q;
    assign wr_res      = wr_res_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_rfphoenix_mc_wb_queue.sv
// tb_rfphoenix_mc_wb_queue: scoreboard bench with a queue-based reference model of the writeback collector
module tb_rfphoenix_mc_wb_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        en;
        logic [3:0]  rid;
        logic [31:0] res;
        logic        ovf;
        logic        ok;
    } obs_t;

    logic clk = 1'b0, rst = 1'b1;
    logic mc_issue = 1'b0, mc_valid = 1'b0, sc_valid = 1'b0;
    logic [3:0] mc_rid = '0, sc_rid = '0;
    logic [31:0] mc_res = '0, sc_res = '0;
    logic wr_en, mc_issue_ok, ovf;
    logic [3:0] wr_rid;
    logic [31:0] wr_res;

    int compared = 0, mismatched = 0;
    obs_t exp_q[$];
    logic [35:0] mq[$];
    int m_infl = 0;
    logic m_ovf = 1'b0;
    logic [3:0] m_rid = '0;
    logic [31:0] m_res = '0;

    rfphoenix_mc_wb_queue #(.WID(32), .RIDW(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mc_issue(mc_issue), .mc_valid(mc_valid), .mc_rid(mc_rid),
        .mc_res(mc_res), .sc_valid(sc_valid), .sc_rid(sc_rid), .sc_res(sc_res), .wr_en(wr_en),
        .wr_rid(wr_rid), .wr_res(wr_res), .mc_issue_ok(mc_issue_ok), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Monitor: each clock, compare what the DUT presents against the oldest expected observation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{wr_en, wr_rid, wr_res, ovf, mc_issue_ok};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL obs#%0d: got en=%b rid=%0d res=%h ovf=%b ok=%b, want en=%b rid=%0d res=%h ovf=%b ok=%b",
                         compared, a.en, a.rid, a.res, a.ovf, a.ok, e.en, e.rid, e.res, e.ovf, e.ok);
            end
        end
    end

    task automatic mc_capture(input bit mv, input logic [35:0] v);
        if (mv) begin
            if (mq.size() < DEPTH) mq.push_back(v);
            else m_ovf = 1'b1;
        end
    endtask

    // One clock of stimulus; the model computes what the port must show after this edge
    task automatic step(input bit r, input bit iss, input bit mv, input logic [3:0] mrid,
                        input logic [31:0] mres, input bit sv, input logic [3:0] srid,
                        input logic [31:0] sres);
        obs_t e;
        logic [35:0] w;
        rst = r; mc_issue = iss; mc_valid = mv; mc_rid = mrid; mc_res = mres;
        sc_valid = sv; sc_rid = srid; sc_res = sres;
        e.en = 1'b0;
        if (r) begin
            mq.delete(); m_infl = 0; m_ovf = 1'b0; m_rid = '0; m_res = '0;
        end else begin
            e.en = 1'b1;
            if (sv) begin
                w = {srid, sres};
                mc_capture(mv, {mrid, mres});
            end else if (mq.size() > 0) begin
                w = mq.pop_front();
                mc_capture(mv, {mrid, mres});
            end else if (mv) w = {mrid, mres};
            else begin
                e.en = 1'b0;
                w = {m_rid, m_res};
            end
            {m_rid, m_res} = w;
            if (iss && !mv) m_infl++;
            else if (mv && !iss && m_infl > 0) m_infl--;
        end
        e.rid = m_rid; e.res = m_res; e.ovf = m_ovf;
        e.ok = (mq.size() + m_infl) < DEPTH;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Reset mid-stream with three entries queued behind a busy SC stream
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i + 10), 32'hA000 + i, 1, 4'(i), 32'h5000 + i);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        // Bypass into an empty FIFO
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4'd5, 32'h3F800000, 0, 0, 0);
        idle(2);
        // Collision: SC wins, MC follows one cycle later
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4'd7, 32'h22, 1, 4'd2, 32'h11);
        idle(3);
        // Ordering: four MC results queue behind SC, then a fifth must not bypass them
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 4'(i), 32'h100 * i, 1, 4'd15, 32'hC0DE0000 + i);
        step(0, 0, 1, 4'd9, 32'h900, 0, 0, 0);
        idle(6);
        // Credit: four issues exhaust it, one return restores it
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 4'd3, 32'hBEEF, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i + 4), 32'hF00 + i, 0, 0, 0);
        idle(2);
        // Overflow: five MC results while SC holds the port; the fifth is dropped
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 4'(i + 8), 32'hDEAD0000 + i, 1, 4'd1, 32'h77);
        idle(8);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Randomized traffic respecting the credit protocol
        for (int i = 0; i < 600; i++) begin
            bit iss, mv, sv;
            iss = mc_issue_ok && ($urandom_range(0, 99) < 45);
            mv  = (m_infl > 0) && ($urandom_range(0, 99) < 45);
            sv  = $urandom_range(0, 99) < 40;
            step(0, iss, mv, 4'($urandom), $urandom, sv, 4'($urandom), $urandom);
        end
        idle(12);
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending observations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
